// File: rtl/mux2_pkg.sv
// Shared types for the 2:1 word selector.
// Latency: n/a (types only).
// Backpressure: n/a.
package mux2_pkg;

   localparam int DATA_W = 64;

   typedef logic [DATA_W-1:0] word_t;

endpackage : mux2_pkg

// File: rtl/mux2_word.sv
// Combinational WIDTH-bit 2:1 selector, y = s ? w1 : w0.
// Latency: zero (purely combinational).
// Backpressure: none.
module mux2_word #(
   parameter int WIDTH = mux2_pkg::DATA_W
) (
   input  logic [WIDTH-1:0] w0,
   input  logic [WIDTH-1:0] w1,
   input  logic             s,
   output logic [WIDTH-1:0] y
);

   // Only a definite 1 steers w1; an X/Z select falls through to w0.
   always_comb begin
      if (s) begin
         y = w1;
      end else begin
         y = w0;
      end
   end

endmodule : mux2_word

// File: rtl/mux2_64bit_sel.sv
// 2:1 word selector with combinational f and registered, valid-qualified f_q; MUX2_64BIT_SEL_PARITY_EN adds registered f_par.
// Latency: f zero cycles, f_q/out_valid one cycle.
// Backpressure: none; every in_valid beat is captured, f_q holds while in_valid is low.
module mux2_64bit_sel
   import mux2_pkg::*;
#(
   parameter int               WIDTH   = DATA_W,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] w0,
   input  logic [WIDTH-1:0] w1,
   input  logic             s,
   input  logic             in_valid,
   output logic [WIDTH-1:0] f,
   output logic [WIDTH-1:0] f_q,
   output logic             out_valid
`ifdef MUX2_64BIT_SEL_PARITY_EN
   ,
   output logic             f_par
`endif
);

   logic [WIDTH-1:0] sel_dat;

   // One selector feeds both the same-cycle output and the register input.
   mux2_word #(
      .WIDTH (WIDTH)
   ) u_sel (
      .w0 (w0),
      .w1 (w1),
      .s  (s),
      .y  (sel_dat)
   );

   assign f = sel_dat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_q       <= RST_VAL;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            f_q <= sel_dat;
         end
      end
   end

`ifdef MUX2_64BIT_SEL_PARITY_EN
   // Shares f_q's enable and reset so f_par always tracks ^f_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_par <= ^RST_VAL;
      end else if (in_valid) begin
         f_par <= ^sel_dat;
      end
   end
`endif

endmodule : mux2_64bit_sel

// File: tb/tb_mux2_64bit_sel.sv
// Self-checking bench for mux2_64bit_sel: directed steps plus a randomized run against a reference model.
module tb_mux2_64bit_sel;
   import mux2_pkg::*;

   localparam int W = DATA_W;

   logic         clk      = 1'b0;
   logic         clk_run  = 1'b0;
   logic         rst_n    = 1'b1;
   logic         s        = 1'b0;
   logic         in_valid = 1'b0;
   word_t        w0       = '0;
   word_t        w1       = '0;
   word_t        f;
   word_t        f_q;
   logic         out_valid;
`ifdef MUX2_64BIT_SEL_PARITY_EN
   logic         f_par;
`endif

   int    total = 0;
   int    bad   = 0;
   word_t exp_q;
   logic  exp_v;

   mux2_64bit_sel #(
      .WIDTH   (W),
      .RST_VAL ('0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .w0        (w0),
      .w1        (w1),
      .s         (s),
      .in_valid  (in_valid),
      .f         (f),
      .f_q       (f_q),
      .out_valid (out_valid)
`ifdef MUX2_64BIT_SEL_PARITY_EN
      ,
      .f_par     (f_par)
`endif
   );

   // Clock only toggles once the bench enables it, so reset can be tested clockless.
   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   task automatic check(input string tag, input word_t obs, input word_t expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".f_q"}, f_q, exp_q);
      check({tag, ".out_valid"}, {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, exp_v});
`ifdef MUX2_64BIT_SEL_PARITY_EN
      check({tag, ".f_par"}, {{(W-1){1'b0}}, f_par}, {{(W-1){1'b0}}, ^exp_q});
`endif
   endtask

   // Drive one beat between edges, check f, clock it, then check the registered view.
   task automatic step(input string tag, input logic v, input logic sel, input word_t a, input word_t b);
      in_valid = v;
      s        = sel;
      w0       = a;
      w1       = b;
      #1;
      check({tag, ".f"}, f, sel ? b : a);
      @(posedge clk);
      if (v) begin
         exp_q = sel ? b : a;
         exp_v = 1'b1;
      end else begin
         exp_v = 1'b0;
      end
      #1;
      check_regs(tag);
   endtask

   initial begin
      // Combinational select with no clock and no reset activity.
      #2;
      w0 = 64'h0123_4567_89AB_CDEF;
      w1 = 64'hFEDC_BA98_7654_3210;
      s  = 1'b0;
      #1 check("comb_s0", f, 64'h0123_4567_89AB_CDEF);
      s  = 1'b1;
      #1 check("comb_s1", f, 64'hFEDC_BA98_7654_3210);

      // Asynchronous reset with the clock stopped.
      rst_n = 1'b0;
      exp_q = '0;
      exp_v = 1'b0;
      #1 check_regs("rst_noclk");
      w1 = 64'hAAAA_AAAA_AAAA_AAAA;
      #1 check("comb_in_rst", f, 64'hAAAA_AAAA_AAAA_AAAA);

      // in_valid during reset must be dropped.
      in_valid = 1'b1;
      clk_run  = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_regs("rst_hold");

      // First capture on the first edge after release.
      @(negedge clk);
      rst_n = 1'b1;
      step("first_cap", 1'b1, 1'b1, 64'h0, 64'hDEAD_BEEF_CAFE_F00D);
      check("first_cap.const", f_q, 64'hDEAD_BEEF_CAFE_F00D);
      step("idle_hold", 1'b0, 1'b0, 64'h5555, 64'h6666);

      // Back-to-back valid beats.
      step("b2b0", 1'b1, 1'b0, 64'h1, 64'h2);
      step("b2b1", 1'b1, 1'b1, 64'h1, 64'h2);
      step("b2b2", 1'b1, 1'b0, 64'h1, 64'h2);
      check("b2b2.const", f_q, 64'h1);

      // Mid-stream reset between edges clears at once; f keeps following inputs.
      #2;
      rst_n = 1'b0;
      exp_q = '0;
      exp_v = 1'b0;
      #1 check_regs("rst_mid");
      check("rst_mid.f", f, 64'h1);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef MUX2_64BIT_SEL_PARITY_EN
      step("par7", 1'b1, 1'b0, 64'h7, 64'h0);
      check("par7.const", {{(W-1){1'b0}}, f_par}, 64'h1);
      step("par3", 1'b1, 1'b0, 64'h3, 64'h0);
      check("par3.const", {{(W-1){1'b0}}, f_par}, 64'h0);
`endif

      // Randomized traffic with occasional asynchronous resets.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            #2;
            rst_n = 1'b0;
            exp_q = '0;
            exp_v = 1'b0;
            #1 check_regs("rnd_rst");
            @(negedge clk);
            rst_n = 1'b1;
         end
         step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              {$urandom, $urandom}, {$urandom, $urandom});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mux2_64bit_sel

// File: doc/mux2_64bit_sel.md
Name: mux2_64bit_sel

Overview:
Two-input, 64-bit-wide word selector with a combinational output and a registered, valid-qualified output copy. Used in datapaths wherever one of two 64-bit operands is steered to a consumer. The combinational output serves same-cycle consumers; the registered output serves pipelined consumers.

Parameters:
WIDTH, 64, data width of w0, w1, f and f_q (must be >=1)
RST_VAL, 0, reset value loaded into f_q (WIDTH bits)

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous active-low reset
w0     input   WIDTH  data input selected when s=0
w1     input   WIDTH  data input selected when s=1
s      input   1      select
in_valid  input  1    qualifies w0/w1/s for the registered path
f      output  WIDTH  combinational result: s ? w1 : w0
f_q    output  WIDTH  registered result
out_valid output 1    f_q holds a result captured from a valid input

Behaviour:
- f = (s==1) ? w1 : w0. Purely combinational, zero latency, independent of clk, rst_n and in_valid; valid during reset.
- s is X/Z: f resolves to w0 (decision: the explicit test is s==1'b1; anything else selects w0).
- Registered path, 1-cycle latency: on posedge clk with in_valid=1, f_q <= (s ? w1 : w0) and out_valid <= 1.
- On posedge clk with in_valid=0: f_q holds its value; out_valid <= 0.
- No back-pressure; every valid input is accepted and produces a result on the next cycle. Back-to-back valid inputs produce back-to-back results.
- Reset (rst_n=0, asynchronous, no clock needed): f_q = RST_VAL, out_valid = 0 immediately. Held while rst_n=0; an in_valid asserted during reset is dropped.
- Reset release: the first capture occurs on the first posedge with rst_n=1.
- Reset asserted mid-stream: any pending result is discarded; f is unaffected.
- Width rule: all data paths are exactly WIDTH bits; no extension or truncation.

Optional Feature:
MUX2_64BIT_SEL_PARITY_EN
- Defined: adds output f_par (1 bit), even parity (XOR-reduce) of the selected word. It is registered alongside f_q: same enable as f_q (in_valid), reset to the XOR-reduce of RST_VAL, and held when in_valid=0. f_par always equals ^f_q.
- Undefined: port f_par and its logic are absent; all other behaviour is identical.

Decomposition:
- Package mux2_pkg: localparam DATA_W=64 (default for WIDTH); typedef logic [DATA_W-1:0] word_t.
- One sub-module, mux2_word: parameterized combinational WIDTH-bit 2:1 selector (w0, w1, s -> y). The top instantiates it once to drive both f and the f_q D-input, so both paths share one selection function.

Test Plan:
- s=0, w0=64'h0123_4567_89AB_CDEF, w1=64'hFEDC_BA98_7654_3210 -> f=64'h0123_4567_89AB_CDEF in the same time step. Set s=1 -> f=64'hFEDC_BA98_7654_3210 with no clock edge.
- rst_n=0 with no clock running -> f_q=0, out_valid=0 immediately. Meanwhile s=1, w1=64'hAAAA_AAAA_AAAA_AAAA -> f=64'hAAAA_AAAA_AAAA_AAAA.
- After reset, in_valid=1, s=1, w1=64'hDEAD_BEEF_CAFE_F00D for one cycle -> next cycle f_q=64'hDEAD_BEEF_CAFE_F00D and out_valid=1. The following cycle with in_valid=0 -> out_valid=0 and f_q holds.
- Back-to-back valid inputs with s=0,1,0, w0=64'h1, w1=64'h2 -> f_q=1,2,1 on consecutive cycles with out_valid=1 throughout.
- Assert rst_n=0 between clock edges while out_valid=1 -> f_q=0 and out_valid=0 at once, without waiting for the next edge.
- PARITY_EN defined: capture 64'h0000_0000_0000_0007 -> f_par=1; capture 64'h0000_0000_0000_0003 -> f_par=0.
